// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..NR one per handshake,
// computing each next key on the fly from the registered current key.

// SubBytes over numbytes bytes. The S-box is computed as GF(2^8) inverse
// (x^254, with 0 mapping to 0) followed by the AES affine transform.
module SubBytes #(
  parameter int unsigned numbytes = 16
) (
  input  logic [numbytes*8-1:0] data_in,
  output logic [numbytes*8-1:0] data_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    // x^254 = x^2 * x^4 * ... * x^128
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte-wise substitution
  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < numbytes; i++) begin
      data_out[i*8 +: 8] = sbox(data_in[i*8 +: 8]);
    end
  end

endmodule

module aes_key_expand #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_num_q, round_num_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic         hs;
  logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7;
  logic [31:0]  rot_w3, sub_w3, t;

  assign hs = (state_q == EMIT) && rk_ready;
  assign {w0, w1, w2, w3} = round_key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  SubBytes #(.numbytes(4)) u_subword (
    .data_in  (rot_w3),
    .data_out (sub_w3)
  );

  // Next round key from the registered current key
  always_comb begin
    t  = sub_w3 ^ {rcon_q, 24'h0};
    w4 = w0 ^ t;
    w5 = w1 ^ w4;
    w6 = w2 ^ w5;
    w7 = w3 ^ w6;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_num_q <= '0;
      rcon_q      <= 8'h01;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_num_q <= round_num_d;
      rcon_q      <= rcon_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EMIT;
      EMIT:    if (hs && (round_num_q == LAST)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: latch on start, advance on handshake, pulse done after last
  always_comb begin
    round_key_d = round_key_q;
    round_num_d = round_num_q;
    rcon_d      = rcon_q;
    done_d      = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        round_key_d = key_in;
        round_num_d = '0;
        rcon_d      = 8'h01;
      end
    end else if (hs) begin
      if (round_num_q == LAST) begin
        done_d = 1'b1;
      end else begin
        round_key_d = {w4, w5, w6, w7};
        round_num_d = round_num_q + 4'd1;
        rcon_d      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
      end
    end
  end

  // Outputs are all register-derived; rk_ready never reaches an output combinationally
  always_comb begin
    rk_valid  = (state_q == EMIT);
    busy      = (state_q == EMIT);
    done      = done_q;
    round_key = round_key_q;
    round_num = round_num_q;
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 A.1 schedule, backpressure,
// zero key, ignored start, mid-expansion reset, and an NR=4 instance.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, rk_ready;
  logic [127:0] key_in;
  logic         rk_valid, busy, done;
  logic [127:0] round_key;
  logic [3:0]   round_num;

  logic         start4, rk_ready4;
  logic [127:0] key4;
  logic         rk_valid4, busy4, done4;
  logic [127:0] round_key4;
  logic [3:0]   round_num4;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] exp_k  [0:10];
  bit           exp_kn [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  aes_key_expand #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .rk_ready(rk_ready),
    .rk_valid(rk_valid), .round_key(round_key), .round_num(round_num),
    .busy(busy), .done(done)
  );

  aes_key_expand #(.NR(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .key_in(key4), .rk_ready(rk_ready4),
    .rk_valid(rk_valid4), .round_key(round_key4), .round_num(round_num4),
    .busy(busy4), .done(done4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_fips();
    exp_k[0]  = FIPS_KEY;
    exp_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i <= 10; i++) exp_kn[i] = 1'b1;
  endtask

  task automatic set_zero();
    for (int i = 0; i <= 10; i++) begin
      exp_kn[i] = 1'b0;
      exp_k[i]  = '0;
    end
    exp_kn[0]  = 1'b1;
    exp_kn[1]  = 1'b1;
    exp_kn[10] = 1'b1;
    exp_k[1]   = 128'h62636363626363636263636362636363;
    exp_k[10]  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  endtask

  // Full expansion on the NR=10 instance using exp_k/exp_kn.
  task automatic expand(input logic [127:0] k, input bit bp, input bit inj);
    int  r = 0;
    int  cyc = 0;
    bit  rdy;
    bit  injected = 1'b0;
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (r <= 10 && cyc < 600) begin
      chk("rk_valid", 128'(rk_valid), 128'd1);
      chk("busy", 128'(busy), 128'd1);
      chk("round_num", 128'(round_num), 128'(r));
      if (exp_kn[r]) chk($sformatf("round_key[%0d]", r), round_key, exp_k[r]);
      rdy = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (inj && r == 3 && !injected) begin
        start    = 1'b1;
        key_in   = ALT_KEY;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      rk_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) r++;
    end
    start    = 1'b0;
    rk_ready = 1'b0;
    chk("expand_timeout", 128'(cyc < 600), 128'd1);
    chk("done_pulse", 128'(done), 128'd1);
    chk("valid_after_last", 128'(rk_valid), 128'd0);
    chk("busy_after_last", 128'(busy), 128'd0);
    chk("round_num_hold", 128'(round_num), 128'd10);
    if (exp_kn[10]) chk("round_key_hold", round_key, exp_k[10]);
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'd0);
  endtask

  // Walks the NR=4 instance from round 0 to the done cycle; start4 already pulsed.
  task automatic loop4();
    int r = 0;
    int cyc = 0;
    while (r <= 4 && cyc < 50) begin
      chk("rk_valid4", 128'(rk_valid4), 128'd1);
      chk("round_num4", 128'(round_num4), 128'(r));
      if (exp_kn[r]) chk($sformatf("round_key4[%0d]", r), round_key4, exp_k[r]);
      rk_ready4 = 1'b1;
      @(negedge clk);
      cyc++;
      r++;
    end
    chk("expand4_timeout", 128'(cyc < 50), 128'd1);
    chk("done4_pulse", 128'(done4), 128'd1);
    chk("busy4_after_last", 128'(busy4), 128'd0);
    chk("round_num4_hold", 128'(round_num4), 128'd4);
  endtask

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    start4 = 1'b0; rk_ready4 = 1'b0; key4 = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 128'(rk_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_round_num", 128'(round_num), 128'd0);
    chk("reset_round_key", round_key, 128'd0);
    rst = 1'b0;

    // rk_ready while idle must not start anything
    rk_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready_valid", 128'(rk_valid), 128'd0);
    rk_ready = 1'b0;

    set_fips();
    expand(FIPS_KEY, 1'b0, 1'b0);
    expand(FIPS_KEY, 1'b1, 1'b0);
    set_zero();
    expand(128'd0, 1'b0, 1'b0);
    set_fips();
    expand(FIPS_KEY, 1'b1, 1'b1);

    // Reset in the middle of a stall at round 5
    @(negedge clk);
    key_in = FIPS_KEY;
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    rk_ready = 1'b1;
    w = 0;
    while (round_num != 4'd5 && w < 30) begin
      @(negedge clk);
      w++;
    end
    rk_ready = 1'b0;
    chk("reach_round5", 128'(w < 30), 128'd1);
    repeat (2) @(negedge clk);
    chk("stall_round_num", 128'(round_num), 128'd5);
    chk("stall_round_key", round_key, exp_k[5]);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 128'(rk_valid), 128'd0);
    chk("async_rst_busy", 128'(busy), 128'd0);
    chk("async_rst_done", 128'(done), 128'd0);
    chk("async_rst_round_num", 128'(round_num), 128'd0);
    chk("async_rst_round_key", round_key, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    expand(FIPS_KEY, 1'b0, 1'b0);

    // NR=4 instance: back-to-back expansions, second start on the done cycle
    set_fips();
    @(negedge clk);
    key4   = FIPS_KEY;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    loop4();
    set_zero();
    exp_kn[10] = 1'b0;
    start4    = 1'b1;
    key4      = '0;
    rk_ready4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    loop4();
    rk_ready4 = 1'b0;
    @(negedge clk);
    chk("done4_one_cycle", 128'(done4), 128'd0);
    chk("valid4_idle", 128'(rk_valid4), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
